// File: rtl/inst_fetch.sv
// Instruction fetch sequencer for a 4-bit machine-cycle CPU.
// Runs an 8-phase machine cycle: it drives the PC nibble to the ROM bus in
// phases 0-2, latches the opcode nibbles in phases 3-4, tracks two-word
// instructions and issues PC stack commands.
// Optional feature: define INST_FETCH_COUNT_EN to build the retired-instruction
// counter; otherwise inst_count is tied to zero.
module inst_fetch #(
  parameter logic [2:0] SYNC_CYCLE = 3'd7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       halt,
  input  logic [3:0] pc_word,
  input  logic       pc_enable,
  input  logic [3:0] bus_in,
  output logic [3:0] bus_out,
  output logic       bus_oe,
  output logic       sync,
  output logic [2:0] cycle,
  output logic [3:0] opr,
  output logic [3:0] opa,
  output logic       second_word,
  output logic       inst_valid,
  output logic [1:0] stack_control,
  output logic [7:0] inst_count
);

  localparam logic [1:0] STK_NOP  = 2'b00;
  localparam logic [1:0] STK_PUSH = 2'b01;
  localparam logic [1:0] STK_POP  = 2'b10;

  logic two_word;
  logic advance;

  // Every register holds while halted.
  assign advance = ~halt;

  // Opcodes whose instruction occupies two ROM words (FIM is opr=2 with even opa).
  assign two_word = (opr == 4'h1) || (opr == 4'h4) || (opr == 4'h5) ||
                    (opr == 4'h7) || ((opr == 4'h2) && !opa[0]);

  // Machine-cycle phase counter, wrapping 7 -> 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle <= 3'd0;
    end else if (advance) begin
      cycle <= cycle + 3'd1;
    end
  end

  // Opcode nibble capture: upper nibble in phase 3, lower nibble in phase 4.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opr <= 4'h0;
      opa <= 4'h0;
    end else if (advance) begin
      if (cycle == 3'd3) opr <= bus_in;
      if (cycle == 3'd4) opa <= bus_in;
    end
  end

  // Fresh-instruction strobe, high for exactly phase 5.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inst_valid <= 1'b0;
    end else if (advance) begin
      inst_valid <= (cycle == 3'd4);
    end
  end

  // Word-2 flag toggles in only after word 1 of a two-word opcode, so a run of
  // two-word opcodes alternates 0,1,0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      second_word <= 1'b0;
    end else if (advance && (cycle == 3'd7)) begin
      second_word <= two_word & ~second_word;
    end
  end

`ifdef INST_FETCH_COUNT_EN
  // Retire count: bumps at the end of every machine cycle that was not word 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inst_count <= 8'h00;
    end else if (advance && (cycle == 3'd7) && !(two_word && !second_word)) begin
      inst_count <= inst_count + 8'd1;
    end
  end
`else
  assign inst_count = 8'h00;
`endif

  // ROM address drive is only enabled during the address phases 0-2.
  always_comb begin
    bus_out = 4'h0;
    bus_oe  = 1'b0;
    if (cycle <= 3'd2) begin
      bus_out = pc_word;
      bus_oe  = pc_enable;
    end
  end

  assign sync = (cycle == SYNC_CYCLE);

  // Stack command: PUSH on word 2 of JMS, POP on BBL; opr/second_word only
  // change at phases 3 and 7, so the stack sees a steady value at phase 2.
  always_comb begin
    stack_control = STK_NOP;
    if (second_word && (opr == 4'h5)) begin
      stack_control = STK_PUSH;
    end else if (!second_word && (opr == 4'hC)) begin
      stack_control = STK_POP;
    end
  end

endmodule
